// File: rtl/sup_counter_if.sv
// Handshake/data bundle for sup_counter: control and load value toward the
// counter, registered count and status flags back from it.
interface sup_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] o;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, ld, d,
    input  o, tc, wrap, ovf
  );

  modport slave (
    input  en, ld, d,
    output o, tc, wrap, ovf
  );
endinterface

// File: rtl/sup_counter.sv
// Synchronous modulo-(MAX+1) up counter with enable, clamped parallel load,
// terminal-count flag, wrap pulse and sticky overflow; SUP_COUNTER_SATURATE_EN selects saturation.
module sup_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 7
) (
  input  logic        c,
  input  logic        r,
  sup_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] o_q,    o_next;
  logic             wrap_q, wrap_next;
  logic             ovf_q,  ovf_next;

  // NOTE: every variable gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    o_next    = o_q;
    wrap_next = 1'b0;
    ovf_next  = ovf_q;
    if (bus.ld) begin
      o_next   = (bus.d > MAX_V) ? MAX_V : bus.d;
      ovf_next = 1'b0;
    end else if (bus.en) begin
      if (o_q == MAX_V) begin
`ifdef SUP_COUNTER_SATURATE_EN
        o_next    = MAX_V;
`else
        o_next    = '0;
        wrap_next = 1'b1;
`endif
        ovf_next  = 1'b1;
      end else begin
        // Increment only happens below MAX, so it cannot overflow WIDTH bits.
        o_next = o_q + WIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all three update
  // together from the values sampled at the same edge.
  always_ff @(posedge c) begin
    if (r) begin
      o_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      o_q    <= o_next;
      wrap_q <= wrap_next;
      ovf_q  <= ovf_next;
    end
  end

  assign bus.o    = o_q;
  assign bus.tc   = (o_q == MAX_V);
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_sup_counter.sv
// Self-checking bench for sup_counter (WIDTH=3, MAX=5): directed test-plan
// steps followed by random stimulus, all against a behavioural model.
module tb_sup_counter;
  localparam int WIDTH = 3;
  localparam int MAX   = 5;

  logic c = 1'b0;
  logic r = 1'b1;

  sup_counter_if #(.WIDTH(WIDTH)) bus ();

  sup_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .c   (c),
    .r   (r),
    .bus (bus)
  );

  always #5 c = ~c;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural reference state.
  int m_cnt  = 0;
  bit m_wrap = 1'b0;
  bit m_ovf  = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rr, input bit ll, input bit ee, input int dd);
    if (rr) begin
      m_cnt = 0; m_wrap = 0; m_ovf = 0;
    end else if (ll) begin
      m_cnt = (dd > MAX) ? MAX : dd; m_wrap = 0; m_ovf = 0;
    end else if (ee) begin
      if (m_cnt == MAX) m_ovf = 1;
`ifdef SUP_COUNTER_SATURATE_EN
      m_wrap = 0;
      m_cnt  = (m_cnt + 1 > MAX) ? MAX : m_cnt + 1;
`else
      m_wrap = (m_cnt == MAX);
      m_cnt  = (m_cnt + 1) % (MAX + 1);
`endif
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".o"},    int'(bus.o),    m_cnt);
    check({tag, ".tc"},   int'(bus.tc),   int'(m_cnt == MAX));
    check({tag, ".wrap"}, int'(bus.wrap), int'(m_wrap));
    check({tag, ".ovf"},  int'(bus.ovf),  int'(m_ovf));
  endtask

  // Drive inputs, clock one edge, update the model, sample 1 time unit later.
  task automatic step(input string tag, input bit rr, input bit ll, input bit ee, input int dd);
    r      = rr;
    bus.ld = ll;
    bus.en = ee;
    bus.d  = WIDTH'(dd);
    @(posedge c);
    model_edge(rr, ll, ee, dd);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.ld = 1'b0;
    bus.d  = '0;

    // Reset then count through one rollover.
    step("rst0", 1, 0, 0, 0);
    step("rst1", 1, 0, 0, 0);
    check("rst_o_const", int'(bus.o), 0);
    for (int i = 0; i < 7; i++) step("count", 0, 0, 1, 0);
    check("count_end_o", int'(bus.o), 1);
    check("count_end_ovf", int'(bus.ovf), 1);

    // Load and clamp.
    step("ld3", 0, 1, 0, 3);
    check("ld3_o", int'(bus.o), 3);
    step("ld7", 0, 1, 0, 7);
    check("ld7_clamp", int'(bus.o), 5);

    // Load beats enable at MAX; reset beats load.
    step("ld_en_at_max", 0, 1, 1, 2);
    check("ld_en_o", int'(bus.o), 2);
    step("rst_ld", 1, 1, 1, 4);

    // Count to 4, then hold.
    for (int i = 0; i < 4; i++) step("to4", 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("hold", 0, 0, 0, 0);
    check("hold_o", int'(bus.o), 4);

    // Reset mid-count with ovf set, then resume.
    for (int i = 0; i < 5; i++) step("to3", 0, 0, 1, 0);
    step("rst_mid", 1, 0, 1, 0);
    step("resume1", 0, 0, 1, 0);
    step("resume2", 0, 0, 1, 0);

    // From 0, hold enable for 8 cycles (modulo or saturate per build).
    step("zero", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("run8", 0, 0, 1, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
